systolic_job_scheduler: RTL

SYSTOLIC_JOB_SCHEDULER -- requirements
Module: systolic_job_scheduler

---
 rtl/systolic_sched_pkg.sv | 15 +
 rtl/sched_job_fifo.sv | 61 ++++++
 rtl/systolic_job_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/systolic_sched_pkg.sv
// Shared FSM state encoding and completion status codes for the systolic job scheduler.
package systolic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    REPORT    = 2'd3
  } sched_state_e;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_ABORT   = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

endpackage

// File: rtl/sched_job_fifo.sv
// Power-of-two job FIFO holding {tag, inst_base}; accepts a push while full when a pop
// happens in the same cycle.
module sched_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // pointers wrap naturally because DEPTH is a power of two
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/systolic_job_scheduler.sv
// Job queue + launch/complete FSM in front of the systolic top.
// Define SYSTOLIC_SCHED_TIMEOUT_EN to enable the WAIT_DONE watchdog.
`ifndef SYSTOLIC_ADDR_WIDTH
`define SYSTOLIC_ADDR_WIDTH 32
`endif
module systolic_job_scheduler
  import systolic_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = `SYSTOLIC_ADDR_WIDTH,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [ADDR_WIDTH-1:0]        job_inst_base,
  input  logic [TAG_WIDTH-1:0]         job_tag,
  output logic                         sys_start,
  output logic [ADDR_WIDTH-1:0]        sys_inst_base,
  input  logic                         sys_done,
  output logic                         cmpl_valid,
  input  logic                         cmpl_ready,
  output logic [TAG_WIDTH-1:0]         cmpl_tag,
  output logic [1:0]                   cmpl_status,
  input  logic                         abort,
  output logic                         busy,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);
  localparam int EW = TAG_WIDTH + ADDR_WIDTH;

  if (QUEUE_DEPTH < 2 || QUEUE_DEPTH > 16 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("systolic_job_scheduler: illegal QUEUE_DEPTH or TIMEOUT_CYCLES");
  end

  sched_state_e          state_q, state_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]            status_q, status_d;
  logic [EW-1:0]         head;
  logic                  fifo_pop, fifo_full, fifo_empty;

`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  sched_job_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (job_valid && job_ready),
    .wdata ({job_tag, job_inst_base}),
    .pop   (fifo_pop),
    .rdata (head),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign job_ready     = !fifo_full;
  assign sys_start     = (state_q == LAUNCH);
  assign sys_inst_base = base_q;
  assign cmpl_valid    = (state_q == REPORT);
  assign cmpl_tag      = tag_q;
  assign cmpl_status   = status_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    base_d   = base_q;
    status_d = status_q;
    fifo_pop = 1'b0;
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop        = 1'b1;
          {tag_d, base_d} = head;
          state_d         = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      WAIT_DONE: begin
        // completion wins over a coincident abort
        if (sys_done) begin
          status_d = STATUS_OK;
          state_d  = REPORT;
        end else if (abort) begin
          status_d = STATUS_ABORT;
          state_d  = REPORT;
        end
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
        else if (tmo_hit) begin
          status_d = STATUS_TIMEOUT;
          state_d  = REPORT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      REPORT: begin
        if (cmpl_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      base_q   <= '0;
      status_q <= STATUS_OK;
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      base_q   <= base_d;
      status_q <= status_d;
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

endmodule
